// File: rtl/wdt_pkg.sv
// Shared definitions for the wdt watchdog: register map, bit positions, FSM states.
// The optional feed window is built only when WDT_WINDOW_EN is defined.
package wdt_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_LOCK_BIT   = 2;
  localparam int CTRL_WIN_LSB    = 16;

  localparam int STATUS_WARN_BIT = 0;
  localparam int STATUS_VIOL_BIT = 1;

  localparam logic [31:0] DEFAULT_FEED_KEY = 32'h5A5A_A5A5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WARN,
    ST_BITE
  } wdt_state_e;

  // A zero reload would expire immediately, so it is stored as 1.
  function automatic logic [31:0] sanitize_load(input logic [31:0] value);
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage

// File: rtl/wdt_counter.sv
// 32-bit down-counter for the watchdog: load has priority over decrement.
module wdt_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        dec_en,
  output logic [31:0] count,
  output logic        zero
);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec_en) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/wdt.sv
// Watchdog timer peripheral: warning irq on first expiry, reset request on second.
// Define WDT_WINDOW_EN to enable the CTRL.WIN early-feed window check.
module wdt
  import wdt_pkg::*;
#(
  parameter logic [31:0] FEED_KEY = DEFAULT_FEED_KEY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq,
  output logic        sys_reset_req
);

  wdt_state_e  state;
  logic        ctrl_en;
  logic        ctrl_irq_en;
  logic        ctrl_lock;
  logic [31:0] load_reg;
  logic        status_warn;
`ifdef WDT_WINDOW_EN
  logic [15:0] ctrl_win;
  logic        status_viol;
`endif

  logic [31:0] count;
  logic        cnt_zero;
  logic        cnt_load;
  logic        cnt_dec;

  logic wr_ok, ctrl_wr, load_wr, status_wr, feed_wr, disable_wr;
  logic window_hit, feed_ok, feed_viol, expire, warn_set;

  // Nothing is writable once the watchdog has bitten.
  assign wr_ok      = write_enable && (state != ST_BITE);
  assign ctrl_wr    = wr_ok && (addr == REG_CTRL) && !ctrl_lock;
  assign load_wr    = wr_ok && (addr == REG_LOAD) && !ctrl_lock;
  assign status_wr  = wr_ok && (addr == REG_STATUS);
  assign feed_wr    = wr_ok && (addr == REG_COUNT) && (write_data == FEED_KEY)
                      && ((state == ST_RUN) || (state == ST_WARN));
  assign disable_wr = ctrl_wr && !write_data[CTRL_EN_BIT];

`ifdef WDT_WINDOW_EN
  assign window_hit = (ctrl_win != 16'h0) && (count > {ctrl_win, 16'h0000});
`else
  assign window_hit = 1'b0;
`endif

  assign feed_ok   = feed_wr && !window_hit;
  assign feed_viol = feed_wr && window_hit;
  assign expire    = cnt_zero && !feed_wr && !disable_wr;
  assign warn_set  = (state == ST_RUN) && expire;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      ST_IDLE: cnt_load = ctrl_wr && write_data[CTRL_EN_BIT];
      ST_RUN, ST_WARN: begin
        if (feed_ok) begin
          cnt_load = 1'b1;
        end else if (!feed_viol && !disable_wr) begin
          if (cnt_zero) cnt_load = (state == ST_RUN);
          else          cnt_dec  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  wdt_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (load_reg),
    .dec_en     (cnt_dec),
    .count      (count),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      ctrl_en       <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      ctrl_lock     <= 1'b0;
      load_reg      <= '0;
      status_warn   <= 1'b0;
      sys_reset_req <= 1'b0;
`ifdef WDT_WINDOW_EN
      ctrl_win      <= '0;
      status_viol   <= 1'b0;
`endif
    end else begin
      if (ctrl_wr) begin
        ctrl_en     <= write_data[CTRL_EN_BIT];
        ctrl_irq_en <= write_data[CTRL_IRQ_EN_BIT];
        ctrl_lock   <= ctrl_lock | write_data[CTRL_LOCK_BIT];
`ifdef WDT_WINDOW_EN
        ctrl_win    <= write_data[31:CTRL_WIN_LSB];
`endif
      end

      if (load_wr) load_reg <= sanitize_load(write_data);

      // A new expiry outranks a simultaneous write-1-to-clear.
      if (warn_set) begin
        status_warn <= 1'b1;
      end else if (feed_ok || (status_wr && write_data[STATUS_WARN_BIT])) begin
        status_warn <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (ctrl_wr && write_data[CTRL_EN_BIT]) state <= ST_RUN;
        end
        ST_RUN, ST_WARN: begin
          if (feed_viol) begin
            state         <= ST_BITE;
            sys_reset_req <= 1'b1;
`ifdef WDT_WINDOW_EN
            status_viol   <= 1'b1;
`endif
          end else if (feed_ok) begin
            state <= ST_RUN;
          end else if (disable_wr) begin
            state <= ST_IDLE;
          end else if (expire) begin
            if (state == ST_RUN) begin
              state <= ST_WARN;
            end else begin
              state         <= ST_BITE;
              sys_reset_req <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign irq = status_warn && ctrl_irq_en;

  always_comb begin
    read_result = '0;
    unique case (addr)
      REG_CTRL: begin
        read_result[CTRL_EN_BIT]     = ctrl_en;
        read_result[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
        read_result[CTRL_LOCK_BIT]   = ctrl_lock;
`ifdef WDT_WINDOW_EN
        read_result[31:CTRL_WIN_LSB] = ctrl_win;
`endif
      end
      REG_LOAD:  read_result = load_reg;
      REG_COUNT: read_result = count;
      REG_STATUS: begin
        read_result[STATUS_WARN_BIT] = status_warn;
`ifdef WDT_WINDOW_EN
        read_result[STATUS_VIOL_BIT] = status_viol;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wdt.sv
// Self-checking bench for wdt: expectations are queued as stimulus is driven and
// compared in order against sampled register reads and {sys_reset_req, irq}.
`timescale 1ns/1ps
module tb_wdt;
  import wdt_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic        irq;
  logic        sys_reset_req;

  wdt #(.FEED_KEY(KEY)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .read_result   (read_result),
    .irq           (irq),
    .sys_reset_req (sys_reset_req)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] obs[$];
  int          checks = 0;
  int          errors = 0;

  task automatic expect_val(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sample_reg(input logic [1:0] a);
    addr = a;
    #1;
    obs.push_back(read_result);
  endtask

  task automatic sample_pins();
    #1;
    obs.push_back({30'd0, sys_reset_req, irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr         = a;
    write_data   = d;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    write_enable = 1'b0;
    addr         = REG_CTRL;
    write_data   = '0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] o;
    reset_dut();
    expect_val("rst_ctrl", 32'd0);   sample_reg(REG_CTRL);
    expect_val("rst_load", 32'd0);   sample_reg(REG_LOAD);
    expect_val("rst_count", 32'd0);  sample_reg(REG_COUNT);
    expect_val("rst_status", 32'd0); sample_reg(REG_STATUS);
    expect_val("rst_pins", 32'd0);   sample_pins();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = (obs.size() != 0) ? obs.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_timing();
    exp_t e;
    logic [31:0] o;
    int n;
    reset_dut();
    wr(REG_LOAD, 32'd10);
    wr(REG_CTRL, 32'd3);
    expect_val("tm_count_e", 32'd10);     sample_reg(REG_COUNT);
    step(10);
    expect_val("tm_count_e10", 32'd0);    sample_reg(REG_COUNT);
    expect_val("tm_pins_e10", 32'd0);     sample_pins();
    step(1);
    expect_val("tm_status_e11", 32'd1);   sample_reg(REG_STATUS);
    expect_val("tm_pins_e11", 32'd1);     sample_pins();
    expect_val("tm_count_e11", 32'd10);   sample_reg(REG_COUNT);
    n = 11;
    while (!sys_reset_req && n < 60) begin
      step(1);
      n++;
    end
    expect_val("tm_bite_edge", 32'd22);   obs.push_back(n);
    expect_val("tm_pins_bite", 32'd3);    sample_pins();
    wr(REG_CTRL, 32'd0);
    wr(REG_STATUS, 32'd1);
    expect_val("tm_bite_ctrl", 32'd3);    sample_reg(REG_CTRL);
    expect_val("tm_bite_status", 32'd1);  sample_reg(REG_STATUS);
    #2;
    rst = 1'b1;
    expect_val("tm_async_pins", 32'd0);   sample_pins();
    expect_val("tm_async_count", 32'd0);  sample_reg(REG_COUNT);
    @(negedge clk);
    rst = 1'b0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = (obs.size() != 0) ? obs.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_feed();
    exp_t e;
    logic [31:0] o;
    reset_dut();
    wr(REG_LOAD, 32'd5);
    wr(REG_CTRL, 32'd1);
    step(5);
    wr(REG_COUNT, KEY);
    expect_val("fd_zero_feed_count", 32'd5);  sample_reg(REG_COUNT);
    expect_val("fd_zero_feed_status", 32'd0); sample_reg(REG_STATUS);
    step(5);
    wr(REG_COUNT, 32'h1234);
    expect_val("fd_badkey_status", 32'd1);    sample_reg(REG_STATUS);
    expect_val("fd_badkey_count", 32'd5);     sample_reg(REG_COUNT);
    expect_val("fd_irq_masked", 32'd0);       sample_pins();
    step(1);
    wr(REG_COUNT, KEY);
    expect_val("fd_warn_feed_status", 32'd0); sample_reg(REG_STATUS);
    expect_val("fd_warn_feed_count", 32'd5);  sample_reg(REG_COUNT);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = (obs.size() != 0) ? obs.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_disable();
    exp_t e;
    logic [31:0] o;
    reset_dut();
    wr(REG_LOAD, 32'd10);
    wr(REG_CTRL, 32'd1);
    step(2);
    wr(REG_CTRL, 32'd0);
    step(3);
    expect_val("ds_hold_count", 32'd8);   sample_reg(REG_COUNT);
    wr(REG_COUNT, KEY);
    expect_val("ds_idle_feed", 32'd8);    sample_reg(REG_COUNT);
    wr(REG_CTRL, 32'd1);
    expect_val("ds_reenable", 32'd10);    sample_reg(REG_COUNT);
    wr(REG_LOAD, 32'd0);
    expect_val("ds_load_zero", 32'd1);    sample_reg(REG_LOAD);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = (obs.size() != 0) ? obs.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_lock();
    exp_t e;
    logic [31:0] o;
    reset_dut();
    wr(REG_LOAD, 32'd20);
    wr(REG_CTRL, 32'd7);
    wr(REG_CTRL, 32'd0);
    wr(REG_LOAD, 32'd99);
    expect_val("lk_ctrl", 32'd7);          sample_reg(REG_CTRL);
    expect_val("lk_load", 32'd20);         sample_reg(REG_LOAD);
    expect_val("lk_count_running", 32'd18); sample_reg(REG_COUNT);
    wr(REG_COUNT, KEY);
    expect_val("lk_feed", 32'd20);         sample_reg(REG_COUNT);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = (obs.size() != 0) ? obs.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_w1c();
    exp_t e;
    logic [31:0] o;
    reset_dut();
    wr(REG_LOAD, 32'd3);
    wr(REG_CTRL, 32'd3);
    step(4);
    expect_val("wc_irq_set", 32'd1);       sample_pins();
    wr(REG_STATUS, 32'd1);
    expect_val("wc_status_clr", 32'd0);    sample_reg(REG_STATUS);
    expect_val("wc_irq_clr", 32'd0);       sample_pins();
    expect_val("wc_count", 32'd2);         sample_reg(REG_COUNT);
    wr(REG_STATUS, 32'd2);
    expect_val("wc_viol_ro", 32'd0);       sample_reg(REG_STATUS);
    step(2);
    expect_val("wc_still_warn_bite", 32'd2); sample_pins();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = (obs.size() != 0) ? obs.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] o;
    reset_dut();
    wr(REG_LOAD, 32'd3);
    wr(REG_CTRL, 32'd3);
    step(3);
    wr(REG_STATUS, 32'd1);
    expect_val("bb_set_wins", 32'd1);      sample_reg(REG_STATUS);
    expect_val("bb_irq", 32'd1);           sample_pins();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = (obs.size() != 0) ? obs.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_window();
    exp_t e;
    logic [31:0] o;
    reset_dut();
    wr(REG_CTRL, 32'hFFFF_0000);
`ifdef WDT_WINDOW_EN
    expect_val("wn_ctrl_win", 32'hFFFF_0000); sample_reg(REG_CTRL);
    reset_dut();
    wr(REG_LOAD, 32'h0001_0010);
    wr(REG_CTRL, 32'h0001_0001);
    wr(REG_COUNT, KEY);
    expect_val("wn_early_status", 32'd2);   sample_reg(REG_STATUS);
    expect_val("wn_early_pins", 32'd2);     sample_pins();
    reset_dut();
    wr(REG_LOAD, 32'h0001_0010);
    wr(REG_CTRL, 32'h0001_0001);
    step(16);
    wr(REG_COUNT, KEY);
    expect_val("wn_ok_count", 32'h0001_0010); sample_reg(REG_COUNT);
    expect_val("wn_ok_status", 32'd0);        sample_reg(REG_STATUS);
    expect_val("wn_ok_pins", 32'd0);          sample_pins();
`else
    expect_val("wn_ctrl_win_ro", 32'd0);    sample_reg(REG_CTRL);
`endif
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = (obs.size() != 0) ? obs.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    addr         = REG_CTRL;
    write_enable = 1'b0;
    write_data   = '0;
    test_reset();
    test_timing();
    test_feed();
    test_disable();
    test_lock();
    test_w1c();
    test_back_to_back();
    test_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
